// File: rtl/score_bcd_counter.sv
`default_nettype none
// ============================================================================
// score_bcd_counter : packed-BCD score accumulator, ripple add one digit/cycle
// Rev 1.0 : initial release
// ============================================================================
module score_bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add_valid,
  input  logic [3:0]            add_value,
  output logic                  add_ready,
  output logic [4*DIGITS-1:0]   score_digits,
  output logic [4*DIGITS-1:0]   hi_digits,
  output logic                  new_high,
  output logic                  saturated
);

  localparam int                W         = 4 * DIGITS;
  localparam int                IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
  localparam logic [W-1:0]      ALL_NINES = {DIGITS{4'h9}};

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADD    = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [W-1:0]     work_q, work_d;
  logic [3:0]       carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     score_q, score_d;
  logic [W-1:0]     hi_q, hi_d;
  logic             new_high_q, new_high_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic             last_digit;
  logic [3:0]       cur_digit;
  logic [4:0]       digit_sum;
  logic [4:0]       sum_adj;
  logic             digit_carry;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      work_q     <= '0;
      carry_q    <= '0;
      idx_q      <= '0;
      score_q    <= '0;
      hi_q       <= '0;
      new_high_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      new_high_q <= new_high_d;
      sat_q      <= sat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   if (accept) state_d = S_ADD;
        S_ADD:    if (last_digit) state_d = S_UPDATE;
        S_UPDATE: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    add_ready    = (state_q == S_IDLE) && !clear;
    accept       = add_valid && add_ready;
    score_digits = score_q;
    hi_digits    = hi_q;
    new_high     = new_high_q;
    saturated    = sat_q;
  end

  // Select the digit currently being rippled.
  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) cur_digit = work_q[4*i +: 4];
    end
    last_digit  = (idx_q == LAST_IDX);
    digit_sum   = {1'b0, cur_digit} + {1'b0, carry_q};
    sum_adj     = digit_sum - 5'd10;
    digit_carry = (digit_sum > 5'd9);
  end

  always_comb begin
    work_d     = work_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    score_d    = score_q;
    hi_d       = hi_q;
    new_high_d = 1'b0;
    sat_d      = sat_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          work_d  = score_q;
          carry_d = (add_value > 4'd9) ? 4'd9 : add_value;
          idx_d   = '0;
        end
      end
      S_ADD: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) work_d[4*i +: 4] = digit_carry ? sum_adj[3:0] : digit_sum[3:0];
        end
        carry_d = {3'b000, digit_carry};
        idx_d   = idx_q + IDX_W'(1);
        // Carry out of the most significant digit pins the score at all nines.
        if (last_digit && digit_carry) work_d = ALL_NINES;
      end
      S_UPDATE: begin
        score_d = work_q;
        sat_d   = sat_q | (work_q == ALL_NINES);
        if (work_q > hi_q) begin
          hi_d       = work_q;
          new_high_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (clear) begin
      score_d    = '0;
      sat_d      = 1'b0;
      new_high_d = 1'b0;
    end
  end

endmodule
`default_nettype wire
